// File: rtl/vm_pkg.sv
// Shared types and constants for the vending-machine session controller.
// Coin codes follow the core's D_in encoding.
package vm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        DISPENSE,
        REFUND
    } state_e;

    typedef enum logic {
        SLOT_A = 1'b0,
        SLOT_B = 1'b1
    } slot_e;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_HALF = 2'b01;
    localparam logic [1:0] COIN_ONE  = 2'b10;
    localparam logic [1:0] COIN_BAD  = 2'b11;

    // Credit value in half-units; none/bad codes are worth nothing.
    function automatic logic [1:0] coin_value(input logic [1:0] code);
        case (code)
            COIN_HALF: return 2'd1;
            COIN_ONE:  return 2'd2;
            default:   return 2'd0;
        endcase
    endfunction

    function automatic logic is_credit(input logic [1:0] code);
        return (code == COIN_HALF) || (code == COIN_ONE);
    endfunction

endpackage

// File: rtl/vm_rr_arb2.sv
// Two-requester round-robin grant; the pointer register lives in the parent.
// A lone requester always wins; the pointer only breaks ties.
module vm_rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = ptr_i ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/vm_session_ctrl.sv
// Session controller: shares one vending core between coin slots A and B,
// serialises coins into the core, stretches dispense and refunds on timeout.
module vm_session_ctrl
    import vm_pkg::*;
#(
    parameter int DISP_CYCLES = 8,
    parameter int TIMEOUT     = 1000,
    parameter int CREDIT_W    = 3
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [1:0]          a_coin,
    input  logic                a_valid,
    output logic                a_ready,
    input  logic [1:0]          b_coin,
    input  logic                b_valid,
    output logic                b_ready,
    output logic [1:0]          core_D_in,
    output logic                core_clr_n,
    input  logic                core_D_out,
    input  logic                core_D_C,
    output logic                motor,
    output logic                change_a,
    output logic                change_b,
    output logic                refund_a,
    output logic                refund_b,
    output logic [CREDIT_W-1:0] refund_amt,
    output logic                busy,
    output logic                owner
);

    localparam int CNT_MAX = (DISP_CYCLES > TIMEOUT) ? DISP_CYCLES : TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam int SUM_W   = CREDIT_W + 1;

    state_e              state_q, state_d;
    slot_e               owner_q, owner_d;
    slot_e               ptr_q, ptr_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [1:0]          din_q, din_d;
    logic                clr_n_q, clr_n_d;
    logic                motor_q, motor_d;
    logic                change_a_q, change_a_d;
    logic                change_b_q, change_b_d;
    logic                refund_a_q, refund_a_d;
    logic                refund_b_q, refund_b_d;
    logic [CREDIT_W-1:0] amt_q, amt_d;
    logic                busy_q, busy_d;

    logic [1:0]          gnt;
    logic [1:0]          gnt_coin;
    logic [1:0]          own_coin;
    logic                own_valid;
    logic [SUM_W-1:0]    credit_sum;
    logic [CNT_W-1:0]    cnt_inc;

    vm_rr_arb2 u_arb (
        .req_i ({b_valid, a_valid}),
        .ptr_i (ptr_q),
        .gnt_o (gnt)
    );

    assign gnt_coin   = gnt[1] ? b_coin : a_coin;
    assign own_coin   = (owner_q == SLOT_B) ? b_coin : a_coin;
    assign own_valid  = (owner_q == SLOT_B) ? b_valid : a_valid;
    assign credit_sum = {1'b0, credit_q} + SUM_W'(coin_value(din_q));
    assign cnt_inc    = cnt_q + CNT_W'(1);

    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        credit_d   = credit_q;
        cnt_d      = cnt_q;
        din_d      = COIN_NONE;
        clr_n_d    = 1'b1;
        change_a_d = 1'b0;
        change_b_d = 1'b0;
        refund_a_d = 1'b0;
        refund_b_d = 1'b0;
        amt_d      = '0;
        a_ready    = 1'b0;
        b_ready    = 1'b0;

        case (state_q)
            IDLE: begin
                a_ready = gnt[0];
                b_ready = gnt[1];
                if ((gnt != 2'b00) && is_credit(gnt_coin)) begin
                    owner_d = gnt[1] ? SLOT_B : SLOT_A;
                    din_d   = gnt_coin;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                credit_d = credit_sum[CREDIT_W] ? '1 : credit_sum[CREDIT_W-1:0];
                cnt_d    = '0;
                state_d  = WAIT;
            end
            WAIT: begin
                // A dispense request wins over a coin offered in the same cycle.
                if (owner_q == SLOT_A) a_ready = !core_D_out;
                else                   b_ready = !core_D_out;
                if (core_D_out) begin
                    change_a_d = core_D_C && (owner_q == SLOT_A);
                    change_b_d = core_D_C && (owner_q == SLOT_B);
                    cnt_d      = '0;
                    state_d    = DISPENSE;
                end else if (own_valid && is_credit(own_coin)) begin
                    din_d   = own_coin;
                    state_d = ISSUE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(TIMEOUT - 1)) begin
                        clr_n_d    = 1'b0;
                        refund_a_d = (owner_q == SLOT_A);
                        refund_b_d = (owner_q == SLOT_B);
                        amt_d      = credit_q;
                        state_d    = REFUND;
                    end
                end
            end
            DISPENSE: begin
                if (cnt_q == CNT_W'(DISP_CYCLES - 1)) begin
                    credit_d = '0;
                    ptr_d    = (owner_q == SLOT_A) ? SLOT_B : SLOT_A;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            REFUND: begin
                credit_d = '0;
                ptr_d    = (owner_q == SLOT_A) ? SLOT_B : SLOT_A;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign motor_d = (state_d == DISPENSE);
    assign busy_d  = (state_d != IDLE);

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value, independent of statement order.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= IDLE;
            owner_q    <= SLOT_A;
            ptr_q      <= SLOT_A;
            credit_q   <= '0;
            cnt_q      <= '0;
            din_q      <= COIN_NONE;
            clr_n_q    <= 1'b1;
            motor_q    <= 1'b0;
            change_a_q <= 1'b0;
            change_b_q <= 1'b0;
            refund_a_q <= 1'b0;
            refund_b_q <= 1'b0;
            amt_q      <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            credit_q   <= credit_d;
            cnt_q      <= cnt_d;
            din_q      <= din_d;
            clr_n_q    <= clr_n_d;
            motor_q    <= motor_d;
            change_a_q <= change_a_d;
            change_b_q <= change_b_d;
            refund_a_q <= refund_a_d;
            refund_b_q <= refund_b_d;
            amt_q      <= amt_d;
            busy_q     <= busy_d;
        end
    end

    assign core_D_in  = din_q;
    assign core_clr_n = clr_n_q;
    assign motor      = motor_q;
    assign change_a   = change_a_q;
    assign change_b   = change_b_q;
    assign refund_a   = refund_a_q;
    assign refund_b   = refund_b_q;
    assign refund_amt = amt_q;
    assign busy       = busy_q;
    assign owner      = owner_q;

endmodule
